// File: rtl/ahb_mst_pkg.sv
// ahb_mst_pkg: shared types and bus encodings for the ahb_lite_mst initiator.
//   htrans_e     - HTRANS codes driven by the initiator (IDLE, NONSEQ)
//   hburst_e     - HBURST codes driven by the initiator (SINGLE)
//   ahb_cmd_t    - one queued command {write, addr, size, prot, wdata}
//   ahb_rsp_t    - one completed transfer {rdata, err}
package ahb_mst_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000
    } hburst_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [63:0] wdata;
    } ahb_cmd_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } ahb_rsp_t;

endpackage

// File: rtl/ahb_mst_rsp_fifo.sv
// ahb_mst_rsp_fifo: synchronous response FIFO of ahb_rsp_t, no bypass.
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   push_i         - write push_data_i (ignored when full)
//   pop_i          - drop the head entry (ignored when empty)
//   valid_o        - FIFO holds at least one entry
//   data_o         - head entry
//   count_o        - number of stored entries
module ahb_mst_rsp_fifo
    import ahb_mst_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  ahb_rsp_t                       push_data_i,
    input  logic                           pop_i,
    output logic                           valid_o,
    output ahb_rsp_t                       data_o,
    output logic [$clog2(RSP_DEPTH+1)-1:0] count_o
);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    ahb_rsp_t        mem_q [RSP_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign do_push = push_i & (count_q != CW'(RSP_DEPTH));
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (do_pop)  rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) mem_q[wptr_q] <= push_data_i;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ahb_lite_mst.sv
// ahb_lite_mst: command-driven AHB-Lite initiator issuing SINGLE transfers.
//   HCLK, HRESET              - bus clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_*    - command stream (write, addr, size, prot, lane-aligned wdata)
//   rsp_valid/ready, rsp_*    - in-order responses (rdata, err) from an internal FIFO
//   HADDR..HWDATA             - AHB-Lite initiator outputs
//   HREADY, HRESP, HRDATA     - AHB-Lite slave returns
// Outstanding commands are limited by RSP_DEPTH credits so the FIFO never overruns.
module ahb_lite_mst
    import ahb_mst_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [3:0]  cmd_prot,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [63:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [63:0] HRDATA
);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    ahb_cmd_t      aph_q, aph_d;
    logic          aph_valid_q, aph_valid_d;
    logic          dph_valid_q, dph_valid_d;
    logic          dph_write_q, dph_write_d;
    logic [63:0]   dph_wdata_q, dph_wdata_d;
    logic          cancel_q, cancel_d;
    logic [CW-1:0] credits_q, credits_d;

    logic          cmd_accept, aph_advance, dph_done, rsp_pop;
    ahb_rsp_t      push_data, pop_data;
    logic [CW-1:0] fifo_count;

    assign cmd_ready   = (credits_q != '0) & ~cancel_q & (~aph_valid_q | HREADY);
    assign cmd_accept  = cmd_valid & cmd_ready;
    // Address phase completes only when NONSEQ is actually on the bus.
    assign aph_advance = aph_valid_q & ~cancel_q & HREADY;
    assign dph_done    = dph_valid_q & HREADY;
    assign rsp_pop     = rsp_valid & rsp_ready;
    assign push_data   = '{rdata: (dph_write_q ? 64'd0 : HRDATA), err: HRESP};

    always_comb begin
        aph_d       = aph_q;
        aph_valid_d = aph_valid_q;
        dph_valid_d = dph_valid_q;
        dph_write_d = dph_write_q;
        dph_wdata_d = dph_wdata_q;
        cancel_d    = cancel_q;
        credits_d   = credits_q;

        if (cmd_accept) begin
            aph_valid_d = 1'b1;
            aph_d = '{write: cmd_write, addr: cmd_addr, size: cmd_size,
                      prot: cmd_prot, wdata: cmd_wdata};
        end else if (aph_advance) begin
            // Fields keep their value so HADDR/HWRITE/HSIZE/HPROT hold while idle.
            aph_valid_d = 1'b0;
        end

        if (aph_advance) begin
            dph_valid_d = 1'b1;
            dph_write_d = aph_q.write;
            dph_wdata_d = aph_q.wdata;
        end else if (dph_done) begin
            dph_valid_d = 1'b0;
        end

        // Two-cycle ERROR: first cycle (HREADY=0) cancels, second (HREADY=1) ends it.
        if (cancel_q & HREADY)
            cancel_d = 1'b0;
        else if (dph_valid_q & HRESP & ~HREADY)
            cancel_d = 1'b1;

        case ({cmd_accept, rsp_pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            aph_q       <= '0;
            aph_valid_q <= 1'b0;
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_wdata_q <= '0;
            cancel_q    <= 1'b0;
            credits_q   <= CW'(RSP_DEPTH);
        end else begin
            aph_q       <= aph_d;
            aph_valid_q <= aph_valid_d;
            dph_valid_q <= dph_valid_d;
            dph_write_q <= dph_write_d;
            dph_wdata_q <= dph_wdata_d;
            cancel_q    <= cancel_d;
            credits_q   <= credits_d;
        end
    end

    ahb_mst_rsp_fifo #(
        .RSP_DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .push_i     (dph_done),
        .push_data_i(push_data),
        .pop_i      (rsp_pop),
        .valid_o    (rsp_valid),
        .data_o     (pop_data),
        .count_o    (fifo_count)
    );

    // Every stored response still holds its command credit.
    credit_bound: assert property (@(posedge HCLK) disable iff (HRESET)
        (32'(credits_q) + 32'(fifo_count)) <= RSP_DEPTH);

    assign HTRANS    = (aph_valid_q & ~cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = aph_q.addr;
    assign HWRITE    = aph_q.write;
    assign HSIZE     = aph_q.size;
    assign HPROT     = aph_q.prot;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = dph_wdata_q;
    assign rsp_rdata = pop_data.rdata;
    assign rsp_err   = pop_data.err;

endmodule

// File: tb/tb_ahb_lite_mst.sv
// tb_ahb_lite_mst: scoreboard bench for ahb_lite_mst with a 64-bit memory slave
// that can insert wait states or a two-cycle ERROR on one chosen address.
module tb_ahb_lite_mst;
    localparam int unsigned RSP_DEPTH = 4;
    localparam int LOGN = 4096;

    logic        HCLK, HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_prot;
    logic [63:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA, HRDATA;

    ahb_lite_mst #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int unsigned i);
        return {32'hC0DE_0000 + i, ~i};
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return {23'd0, a[11:3]};
    endfunction

    // ---------------- memory slave ----------------
    logic [63:0] mem [512];
    logic        sl_dv, sl_wr, sl_err, sl_err2;
    logic [31:0] sl_addr;
    int          sl_wait;
    logic [31:0] wait_addr = 32'hFFFF_FFF8;
    int          wait_n    = 0;
    logic [31:0] err_addr  = 32'hFFFF_FFF8;
    bit          err_en    = 1'b0;

    assign HREADY = !sl_dv ? 1'b1 : (sl_err ? sl_err2 : (sl_wait == 0));
    assign HRESP  = sl_dv & sl_err;
    assign HRDATA = (sl_dv && !sl_wr) ? mem[widx(sl_addr)] : 64'd0;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int unsigned i = 0; i < 512; i++) mem[i] <= init_word(i);
            sl_dv <= 1'b0; sl_wr <= 1'b0; sl_err <= 1'b0; sl_err2 <= 1'b0;
            sl_addr <= '0; sl_wait <= 0;
        end else begin
            if (sl_dv && sl_err && !sl_err2) sl_err2 <= 1'b1;
            if (sl_dv && !sl_err && sl_wait != 0) sl_wait <= sl_wait - 1;
            if (HREADY) begin
                if (sl_dv && sl_wr && !sl_err) mem[widx(sl_addr)] <= HWDATA;
                sl_dv   <= (HTRANS == 2'b10);
                sl_addr <= HADDR;
                sl_wr   <= HWRITE;
                sl_wait <= (HADDR == wait_addr) ? wait_n : 0;
                sl_err  <= err_en && (HADDR == err_addr);
                sl_err2 <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_mem [512];
    int          cyc = 0;
    int          nxt_lat = -1;
    logic [1:0]  tr_log [LOGN];
    logic [31:0] ad_log [LOGN];
    logic [63:0] wd_log [LOGN];
    logic        rdy_log [LOGN];

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        exp_t e;
        if (cyc < LOGN) begin
            tr_log[cyc]  = HTRANS;
            ad_log[cyc]  = HADDR;
            wd_log[cyc]  = HWDATA;
            rdy_log[cyc] = HREADY;
        end
        if (HRESET) begin
            for (int unsigned i = 0; i < 512; i++) exp_mem[i] = init_word(i);
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                    if (e.lat >= 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (cmd_valid && cmd_ready) begin
                e.err   = cmd_write && err_en && (cmd_addr == err_addr);
                e.rdata = cmd_write ? 64'd0 : exp_mem[widx(cmd_addr)];
                if (cmd_write && !e.err) exp_mem[widx(cmd_addr)] = cmd_wdata;
                e.acc = cyc;
                e.lat = nxt_lat;
                sb.push_back(e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic wr, input logic [31:0] a, input logic [63:0] d,
                        input int lat, input int max_wait, output bit ok, output int acc);
        int t;
        ok = 1'b0; acc = -1; t = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        cmd_size = 3'd3; cmd_prot = 4'h3; nxt_lat = lat;
        forever begin
            @(negedge HCLK);
            if (cmd_ready) begin ok = 1'b1; acc = cyc; break; end
            if (t >= max_wait) begin cmd_valid = 1'b0; break; end
            t++;
        end
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_ok(input logic wr, input logic [31:0] a, input logic [63:0] d,
                           input int lat, output int acc);
        bit ok;
        send(wr, a, d, lat, 50, ok, acc);
        check("cmd_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge HCLK); #1;
            t++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int a[6];
        bit ok;
        int n_acc;

        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = '0; cmd_prot = '0; cmd_wdata = '0; rsp_ready = 1'b1;

        // reset values
        repeat (2) @(negedge HCLK);
        check("rst_htrans", 64'(HTRANS), 64'd0);
        check("rst_haddr", 64'(HADDR), 64'd0);
        check("rst_hwrite", 64'(HWRITE), 64'd0);
        check("rst_hsize", 64'(HSIZE), 64'd0);
        check("rst_hprot", 64'(HPROT), 64'd0);
        check("rst_hwdata", HWDATA, 64'd0);
        check("rst_hburst", 64'(HBURST), 64'd0);
        check("rst_hmastlock", 64'(HMASTLOCK), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_credits", 64'(dut.credits_q), 64'(RSP_DEPTH));
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        @(posedge HCLK); #1;

        // write then read back, zero-wait
        send_ok(1'b1, 32'h1000, 64'h1122334455667788, 3, a[0]);
        send_ok(1'b0, 32'h1000, 64'd0, 3, a[1]);
        drain();

        // four back-to-back reads
        for (int i = 0; i < 4; i++) send_ok(1'b0, 32'h2000 + 32'(8 * i), 64'd0, 3, a[i]);
        drain();
        for (int i = 1; i < 4; i++) check("b2b_accept_cycle", 64'(a[i] - a[0]), 64'(i));
        for (int i = 0; i < 4; i++) begin
            check("b2b_htrans", 64'(tr_log[a[0] + 1 + i]), 64'd2);
            check("b2b_haddr", 64'(ad_log[a[0] + 1 + i]), 64'(32'h2000 + 32'(8 * i)));
        end

        // three wait states on the second write, a read pending behind it
        wait_addr = 32'h3008; wait_n = 3;
        send_ok(1'b1, 32'h3000, 64'hAAAA_0000_0000_0001, 3, a[0]);
        send_ok(1'b1, 32'h3008, 64'hBBBB_0000_0000_0002, 6, a[1]);
        send_ok(1'b0, 32'h3010, 64'd0, 6, a[2]);
        drain();
        check("ws_accept_b", 64'(a[1] - a[0]), 64'd1);
        check("ws_accept_c", 64'(a[2] - a[0]), 64'd2);
        for (int k = 0; k < 3; k++) begin
            check("ws_htrans_held", 64'(tr_log[a[0] + 3 + k]), 64'd2);
            check("ws_haddr_held", 64'(ad_log[a[0] + 3 + k]), 64'h3010);
            check("ws_hwdata_held", wd_log[a[0] + 3 + k], 64'hBBBB_0000_0000_0002);
            check("ws_hready_low", 64'(rdy_log[a[0] + 3 + k]), 64'd0);
        end
        wait_addr = 32'hFFFF_FFF8; wait_n = 0;
        send_ok(1'b0, 32'h3008, 64'd0, 3, a[3]);
        drain();

        // two-cycle error on write A with read B pending
        err_addr = 32'h4000; err_en = 1'b1;
        send_ok(1'b1, 32'h4000, 64'hDEAD_BEEF_DEAD_BEEF, 4, a[0]);
        send_ok(1'b0, 32'h4008, 64'd0, 5, a[1]);
        drain();
        check("err_first_cycle_hready", 64'(rdy_log[a[0] + 2]), 64'd0);
        check("err_htrans_idle", 64'(tr_log[a[0] + 3]), 64'd0);
        check("err_reissue_htrans", 64'(tr_log[a[0] + 4]), 64'd2);
        check("err_reissue_haddr", 64'(ad_log[a[0] + 4]), 64'h4008);
        err_en = 1'b0; err_addr = 32'hFFFF_FFF8;
        send_ok(1'b0, 32'h4000, 64'd0, 3, a[2]);
        drain();

        // credit exhaustion with responses stalled
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 32'h5000 + 32'(8 * i), 64'd0, -1, 8, ok, a[i]);
            n_acc += int'(ok);
        end
        check("credit_accepts", 64'(n_acc), 64'd4);
        @(negedge HCLK);
        check("credit_cmd_ready_low", 64'(cmd_ready), 64'd0);
        check("credit_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge HCLK); #1; rsp_ready = 1'b1;
        @(posedge HCLK); #1; rsp_ready = 1'b0;
        send(1'b0, 32'h5020, 64'd0, -1, 8, ok, a[0]);
        check("credit_one_more", 64'(ok), 64'd1);
        send(1'b0, 32'h5028, 64'd0, -1, 8, ok, a[1]);
        check("credit_blocked_again", 64'(ok), 64'd0);
        rsp_ready = 1'b1;
        drain();

        // reset with transfers in flight
        rsp_ready = 1'b0;
        send_ok(1'b0, 32'h6000, 64'd0, -1, a[0]);
        send_ok(1'b0, 32'h6008, 64'd0, -1, a[1]);
        send_ok(1'b0, 32'h6010, 64'd0, -1, a[2]);
        #1;
        check("pre_rst_htrans", 64'(HTRANS), 64'd2);
        check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        HRESET = 1'b1;
        #1;
        check("mid_rst_htrans", 64'(HTRANS), 64'd0);
        check("mid_rst_haddr", 64'(HADDR), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_credits", 64'(dut.credits_q), 64'(RSP_DEPTH));
        @(negedge HCLK);
        @(posedge HCLK); #1;
        HRESET = 1'b0; rsp_ready = 1'b1;
        send_ok(1'b1, 32'h6000, 64'h0123_4567_89AB_CDEF, 3, a[0]);
        send_ok(1'b0, 32'h6000, 64'd0, 3, a[1]);
        send_ok(1'b0, 32'h6008, 64'd0, 3, a[2]);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_mst.md
# ahb_lite_mst

Command-driven AHB-Lite initiator that turns a valid/ready command stream into single AHB-Lite transfers. It drives the same 64-bit AHB-Lite bus that the testbench memory slave answers, so test sequencers and DMA-style stimulus can reach slave memory without hand-written bus code. Address and data phases are pipelined. Responses return in order through a credit-protected response FIFO.

## Interface
Parameters:
- RSP_DEPTH, 4, response FIFO entries and command credits; must be at least 2.

Ports:
- Clocking and reset: one clock HCLK; reset HRESET is asynchronous and active-high.
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  HSIZE encoding, 0..3.
- cmd_prot  in  4  copied to HPROT.
- cmd_wdata  in  64  write data, already lane-aligned to cmd_addr[2:0].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  64  HRDATA for reads; 0 for writes.
- rsp_err  out  1  the transfer ended with HRESP=1.
- HADDR  out  32
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  64
- HREADY  in  1  the slave's HREADYOUT.
- HRESP  in  1
- HRDATA  in  64

## Operation
- Address-phase register (aph): valid, addr, write, size, prot, wdata. It loads on command acceptance.
- Data-phase register (dph): valid, write, wdata. It loads from aph when HTRANS=NONSEQ and HREADY=1. At that moment aph clears unless a new command is accepted in the same cycle.
- cmd_ready = (credits != 0) & ~cancel & (~aph.valid | HREADY). This is combinational in HREADY.
- Credits counter, range 0..RSP_DEPTH:
  - Decrements on command accept.
  - Increments on response pop.
  - A simultaneous accept and pop leaves it unchanged.
  - It never overflows or underflows, so the FIFO can never overrun.
- HADDR, HWRITE, HSIZE and HPROT come from aph, and hold their last value while aph is empty.
- HTRANS = NONSEQ when aph.valid & ~cancel; otherwise IDLE.
- HWDATA = dph.wdata. It holds through wait states and holds its last value when idle.
- Completion: dph.valid & HREADY pushes {write ? 0 : HRDATA, HRESP} into the FIFO. dph clears unless it is reloaded.
- Error response:
  - Detection: dph.valid & HRESP & ~HREADY is the first error cycle. It sets the registered flag cancel.
  - While cancel=1: HTRANS=IDLE; a pending aph is held and not advanced; cmd_ready=0.
  - cancel clears on the next HREADY=1. That is the second error cycle, in which the erroring transfer completes with rsp_err=1.
  - The held aph is re-presented as NONSEQ in the following cycle.
- Ordering: responses are strictly in command order; there is no reordering and no drop.

## Timing
- Zero-wait slave:
  - Command accepted in cycle 0.
  - NONSEQ on the bus in cycle 1.
  - Data phase in cycle 2.
  - rsp_valid in cycle 3.
  - Each slave wait state adds one cycle.
- Back-to-back throughput is one transfer per cycle when rsp_ready=1, HREADY=1 and RSP_DEPTH >= 4.
- The FIFO has no bypass: a push becomes visible on rsp_valid the next cycle.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HPROT=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cancel=0, credits=RSP_DEPTH.
- cmd_ready becomes 1 in the first cycle after reset deasserts.
- Reset mid-transfer clears aph, dph and the FIFO, discards in-flight commands, and returns the bus to IDLE immediately (asynchronously).
- Credits exhausted: cmd_ready=0, and the bus finishes the outstanding aph and dph normally.

## Structure
- Package ahb_mst_pkg holds:
  - HTRANS_IDLE, HTRANS_NONSEQ, HBURST_SINGLE.
  - The packed struct ahb_cmd_t {write, addr, size, prot, wdata}.
  - The packed struct ahb_rsp_t {rdata, err}.
- Sub-module ahb_mst_rsp_fifo is a synchronous FIFO of ahb_rsp_t, parameterised by RSP_DEPTH, with push, pop, valid and count outputs.

## Test plan
- Write 0x1122334455667788, size 3, to 0x1000, then read 0x1000 with a zero-wait slave. Required: rsp_rdata=0x1122334455667788, rsp_err=0, read response 3 cycles after its accept.
- Four back-to-back reads with rsp_ready=1. Required: HTRANS=NONSEQ for 4 consecutive cycles and 4 responses on consecutive cycles, in order.
- 3 slave wait states on the second of two writes. Required: HADDR and HTRANS held and HWDATA stable for all 3 cycles; response delayed by 3 cycles.
- Two-cycle error on transfer A with B pending. Required: HTRANS=IDLE in the cycle after the first error cycle, A returns rsp_err=1, B re-issued as NONSEQ next and completes with rsp_err=0.
- rsp_ready=0 with RSP_DEPTH=4 and 6 commands offered. Required: exactly 4 accepted and cmd_ready=0 after that; one pop then allows one more accept.
- HRESET asserted with a transfer in the data phase. Required: HTRANS=IDLE, rsp_valid=0, credits=4 immediately; normal operation after release.
